// File: rtl/alu_issue.sv
// Operand-issue stage for the RV32I ALU: decodes OP/OP-IMM, reads the register file, retires results.
// Define ALU_ISSUE_PERF_EN to add the perf_retired / perf_stall counter ports.
//
// state   | meaning
// S_IDLE  | nothing issued, ready for fetch
// S_ISSUE | operands presented to ALU, waiting for out_ready
// S_TRAP  | unsupported opcode accepted, waiting for trap_clear
module alu_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic            alu_is_reg,
  output logic [31:0]     alu_instr,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  input  logic [XLEN-1:0] alu_result,
  output logic            illegal,
  input  logic            trap_clear,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_TRAP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic            out_valid_q, out_valid_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic            accept, retire, legal;
  logic [4:0]      rd_ret, rs1_a, rs2_a;
  logic [XLEN-1:0] op1, op2;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_ISSUE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = (state_q == S_ISSUE) && out_ready;
  assign legal    = (in_instr[6:0] == 7'b0110011) || (in_instr[6:0] == 7'b0010011);

  assign rd_ret = instr_q[11:7];
  assign rs1_a  = in_instr[19:15];
  assign rs2_a  = in_instr[24:20];

  // A result retiring this cycle is not yet in regs_q, so forward it.
  assign op1 = (rs1_a == 5'd0) ? '0 :
               (retire && (rs1_a == rd_ret)) ? alu_result : regs_q[rs1_a];
  assign op2 = (rs2_a == 5'd0) ? '0 :
               (retire && (rs2_a == rd_ret)) ? alu_result : regs_q[rs2_a];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    regs_d  = regs_q;
    if (retire && (rd_ret != 5'd0)) regs_d[rd_ret] = alu_result;
    regs_d[0] = '0;
    case (state_q)
      S_IDLE, S_ISSUE: begin
        if (accept) begin
          if (legal) begin
            state_d = S_ISSUE;
            instr_d = in_instr;
            rs1_d   = op1;
            rs2_d   = op2;
          end else begin
            state_d = S_TRAP;
          end
        end else if (retire) begin
          state_d = S_IDLE;
        end
      end
      S_TRAP:  if (trap_clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_ISSUE);
    illegal_d   = (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      regs_q      <= regs_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign illegal    = illegal_q;
  assign alu_rs1    = rs1_q;
  assign alu_rs2    = rs2_q;
  assign alu_instr  = instr_q;
  assign alu_is_reg = instr_q[5];
  assign alu_funct3 = instr_q[14:12];
  assign alu_funct7 = instr_q[31:25];
  assign dbg_data   = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_retired_d = perf_retired_q + {31'd0, retire};
    perf_stall_d   = perf_stall_q + {31'd0, out_valid_q && !out_ready};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: vector table streamed through a scoreboard plus hand sequences.
// Builds with or without ALU_ISSUE_PERF_EN.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_rs1, alu_rs2, alu_instr;
  logic        alu_is_reg;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_result = '0;
  logic        illegal;
  logic        trap_clear = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  alu_issue dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_is_reg(alu_is_reg),
    .alu_instr(alu_instr), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_result(alu_result), .illegal(illegal), .trap_clear(trap_clear),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
  } exp_t;

  localparam int NVEC = 12;
  vec_t        tbl [NVEC];
  exp_t        sb [$];
  logic [31:0] ref_regs [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] alu_model(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] bv;
    bv = ins[5] ? b : {{20{ins[31]}}, ins[31:20]};
    case (ins[14:12])
      3'd0:    return (ins[5] && ins[30]) ? a - bv : a + bv;
      3'd1:    return a << bv[4:0];
      3'd4:    return a ^ bv;
      3'd6:    return a | bv;
      3'd7:    return a & bv;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] ins, input bit use_model, input logic [31:0] tres);
    exp_t r;
    r.instr = ins;
    r.rs1   = ref_regs[ins[19:15]];
    r.rs2   = ref_regs[ins[24:20]];
    r.res   = use_model ? alu_model(ins, r.rs1, r.rs2) : tres;
    if (ins[11:7] != 5'd0) ref_regs[ins[11:7]] = r.res;
    sb.push_back(r);
  endtask

  // Entered and left at posedge+1.
  task automatic run_stream(input int n, input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit acc, ret;
    while ((idx < n || sb.size() != 0) && cyc < 400) begin
      in_valid  = (idx < n);
      in_instr  = (idx < n) ? tbl[idx].instr : 32'd0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("alu_rs1", alu_rs1, sb[0].rs1);
          chk("alu_rs2", alu_rs2, sb[0].rs2);
          chk("alu_instr", alu_instr, sb[0].instr);
          chk("alu_funct3", {29'd0, alu_funct3}, {29'd0, sb[0].instr[14:12]});
          chk("alu_funct7", {25'd0, alu_funct7}, {25'd0, sb[0].instr[31:25]});
          chk("alu_is_reg", {31'd0, alu_is_reg}, {31'd0, sb[0].instr[5]});
          alu_result = sb[0].res;
        end
      end
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, out_valid ? out_ready : 1'b1});
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      @(posedge clk); #1;
      cyc++;
      if (ret && sb.size() != 0) void'(sb.pop_front());
      if (acc) begin
        push_exp(tbl[idx].instr, rnd, tbl[idx].exp);
        idx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_drain", sb.size() + (n - idx), 32'd0);
    chk("stream_idle", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic dbg_check_all(input string name);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk(name, dbg_data, ref_regs[i]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, hold;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] st0, rt0;
`endif
    tbl[0]  = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1), 32'd5};
    tbl[1]  = '{enc_i(12'd7, 5'd0, 3'd0, 5'd2), 32'd7};
    tbl[2]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd12};
    tbl[3]  = '{enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4), 32'd7};
    tbl[4]  = '{enc_i(12'hfff, 5'd4, 3'd4, 5'd5), 32'hffff_fff8};
    tbl[5]  = '{enc_i(12'd4, 5'd5, 3'd1, 5'd6), 32'hffff_ff80};
    tbl[6]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd12};
    tbl[7]  = '{enc_r(7'h00, 5'd6, 5'd0, 3'd0, 5'd7), 32'hffff_ff80};
    tbl[8]  = '{enc_r(7'h00, 5'd5, 5'd7, 3'd6, 5'd8), 32'hffff_fff8};
    tbl[9]  = '{enc_i(12'd8, 5'd8, 3'd0, 5'd9), 32'd0};
    tbl[10] = '{enc_i(12'd7, 5'd0, 3'd0, 5'd10), 32'd7};
    tbl[11] = '{enc_r(7'h00, 5'd10, 5'd10, 3'd0, 5'd11), 32'd14};
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;

    // Reset state
    #12;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_alu_rs1", alu_rs1, 32'd0);
    chk("rst_alu_instr", alu_instr, 32'd0);
    dbg_check_all("rst_dbg");

    // Back-to-back stream from the table, out_ready held high
    run_stream(NVEC, 1'b0);
    for (int i = 0; i < NVEC; i++) begin
      dbg_addr = tbl[i].instr[11:7];
      #1;
      if (tbl[i].instr[11:7] != 5'd0) chk("tbl_rd", dbg_data, tbl[i].exp);
      else chk("tbl_x0", dbg_data, 32'd0);
    end
    @(posedge clk); #1;

    // Issue latency and a three-cycle stall
    ins = enc_i(12'd5, 5'd0, 3'd0, 5'd12);
    dbg_addr  = 5'd12;
    in_valid  = 1'b1;
    in_instr  = ins;
    out_ready = 1'b0;
    #1 chk("stall_accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_funct3", {29'd0, alu_funct3}, 32'd0);
    chk("lat_is_reg", {31'd0, alu_is_reg}, 32'd0);
    chk("lat_rs1", alu_rs1, 32'd0);
    hold = alu_instr;
    chk("lat_instr", hold, ins);
`ifdef ALU_ISSUE_PERF_EN
    st0 = perf_stall;
    rt0 = perf_retired;
`endif
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_instr", alu_instr, ins);
      chk("stall_no_wb", dbg_data, 32'd0);
      @(posedge clk); #1;
    end
    out_ready  = 1'b1;
    alu_result = 32'd5;
    #1 chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    ref_regs[12] = 32'd5;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_wb", dbg_data, 32'd5);
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_stall", perf_stall - st0, 32'd3);
    chk("perf_retired", perf_retired - rt0, 32'd1);
`endif

    // Illegal opcode (lw) traps; a following instruction is refused
    in_valid = 1'b1;
    in_instr = 32'h0000a103;
    @(posedge clk); #1;
    in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd13);
    chk("trap_illegal", {31'd0, illegal}, 32'd1);
    chk("trap_in_ready", {31'd0, in_ready}, 32'd0);
    chk("trap_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("trap_sticky", {31'd0, illegal}, 32'd1);
    dbg_addr = 5'd2;
    #1 chk("trap_no_wb_x2", dbg_data, ref_regs[2]);
    dbg_addr = 5'd13;
    #1 chk("trap_no_wb_x13", dbg_data, 32'd0);
    trap_clear = 1'b1;
    @(posedge clk); #1;
    trap_clear = 1'b0;
    chk("clear_illegal", {31'd0, illegal}, 32'd0);
    chk("clear_in_ready", {31'd0, in_ready}, 32'd1);
    trap_clear = 1'b1;
    @(posedge clk); #1;
    trap_clear = 1'b0;
    chk("idle_clear_illegal", {31'd0, illegal}, 32'd0);
    chk("idle_clear_out_valid", {31'd0, out_valid}, 32'd0);

    // Random back-pressure, results from the reference ALU
    run_stream(NVEC, 1'b1);
    dbg_check_all("rnd_dbg");

    // Reset while an instruction is waiting to retire
    in_valid  = 1'b1;
    in_instr  = enc_i(12'd9, 5'd0, 3'd0, 5'd14);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_issued", {31'd0, out_valid}, 32'd1);
    alu_result = 32'd9;
    out_ready  = 1'b1;
    #1 resetn = 1'b0;
    #1 chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk) resetn = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_illegal", {31'd0, illegal}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    dbg_check_all("abort_dbg");
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_rst_retired", perf_retired, 32'd0);
    chk("perf_rst_stall", perf_stall, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
